// File: rtl/adding_machine_sequencer.sv
// adding_machine_sequencer
//   Runs one summing job over a run of ROM words: starting at word index
//   'base', it fetches 'count' consecutive words through a two-stage pipeline.
//   Stage 1 registers the ROM data and stage 2 accumulates it. The final sum is
//   then offered to the consumer with a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         job request, sampled only while idle
//   base          first word index of the job, latched with start
//   count         number of words to sum, latched with start
//   hold          freezes fetch/drain progress for the current cycle
//   mem_addr      word index presented to the combinational ROM
//   mem_data      ROM word for mem_addr, same cycle
//   busy          job in progress (fetching or draining)
//   result        accumulated sum, valid while result_valid is high
//   result_valid  result is being offered
//   result_ready  consumer accepts the result
//   overflow      sticky signed overflow of any add in the current job
module adding_machine_sequencer #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic              hold,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] data_q;
    logic              v1;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] result_q;
    logic              ovf_q;

    logic [DATA_W-1:0] sum;
    logic              add_ovf;

    // Stage-2 adder: signed overflow when both operands share a sign and the
    // sum's sign differs from it.
    always_comb begin
        sum     = acc + data_q;
        add_ovf = (acc[DATA_W-1] == data_q[DATA_W-1]) &&
                  (sum[DATA_W-1] != acc[DATA_W-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            index     <= '0;
            remaining <= '0;
            data_q    <= '0;
            v1        <= 1'b0;
            acc       <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index     <= base;
                        remaining <= count;
                        acc       <= '0;
                        ovf_q     <= 1'b0;
                        v1        <= 1'b0;
                        if (count == '0) begin
                            result_q <= '0;
                            state    <= DONE;
                        end else begin
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (!hold) begin
                        data_q    <= mem_data;
                        v1        <= 1'b1;
                        index     <= index + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (v1) begin
                            acc   <= sum;
                            ovf_q <= ovf_q | add_ovf;
                        end
                        // remaining is never 0 here, so it cannot wrap
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!hold) begin
                        v1 <= 1'b0;
                        if (v1) begin
                            acc      <= sum;
                            ovf_q    <= ovf_q | add_ovf;
                            result_q <= sum;
                        end else begin
                            result_q <= acc;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr     = index;
    assign busy         = (state == FETCH) || (state == DRAIN);
    assign result_valid = (state == DONE);
    assign result       = result_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_adding_machine_sequencer.sv
module tb_adding_machine_sequencer;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          result_ready = 1'b0;
    logic [AW-1:0] base = '0;
    logic [CW-1:0] count = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] result;
    logic          busy;
    logic          result_valid;
    logic          overflow;

    int            rom_mode = 0;
    int unsigned   n_chk = 0;
    int unsigned   n_fail = 0;

    adding_machine_sequencer #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base        (base),
        .count       (count),
        .hold        (hold),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // ROM contents: 1 = identity, 2 = alternating 0x7FFFFFFF / 1, else a hash
    function automatic logic [DW-1:0] rom_word(input int mode, input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = DW'(a);
        case (mode)
            1:       return w;
            2:       return a[0] ? 32'h0000_0001 : 32'h7FFF_FFFF;
            default: return (w * 32'h9E37_79B1) ^ (w >> 3) ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign mem_data = rom_word(rom_mode, mem_addr);

    // Job-level reference: plain sum of the words, overflow by checking the
    // true signed sum of each add against the 32-bit signed range.
    function automatic logic [DW-1:0] job_sum(input int mode, input logic [AW-1:0] b, input int unsigned n);
        logic [DW-1:0] s;
        logic [AW-1:0] a;
        s = '0;
        for (int unsigned i = 0; i < n; i++) begin
            a = b + AW'(i);
            s = s + rom_word(mode, a);
        end
        return s;
    endfunction

    function automatic logic job_ovf(input int mode, input logic [AW-1:0] b, input int unsigned n);
        logic [DW-1:0] s;
        logic [AW-1:0] a;
        longint        t;
        logic          o;
        s = '0;
        o = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            a = b + AW'(i);
            t = longint'($signed(s)) + longint'($signed(rom_word(mode, a)));
            if (t > 64'sd2147483647 || t < -64'sd2147483648) o = 1'b1;
            s = s + rom_word(mode, a);
        end
        return o;
    endfunction

    // Model: phase 0 idle, 1 busy, 2 done. A job of count words needs count+1
    // unheld busy cycles; m_cons counts words already addressed.
    int            m_phase = 0;
    logic [AW-1:0] m_base = '0;
    int unsigned   m_cnt = 0;
    int unsigned   m_cons = 0;
    logic [DW-1:0] m_sum = '0;
    logic          m_ovf = 1'b0;
    logic [DW-1:0] m_result = '0;
    logic          m_ovfo = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase  <= 0;
            m_base   <= '0;
            m_cnt    <= 0;
            m_cons   <= 0;
            m_result <= '0;
            m_ovfo   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_base <= base;
                    m_cnt  <= int'(count);
                    m_cons <= 0;
                    m_sum  <= job_sum(rom_mode, base, int'(count));
                    m_ovf  <= job_ovf(rom_mode, base, int'(count));
                    if (count == '0) begin
                        m_phase  <= 2;
                        m_result <= '0;
                        m_ovfo   <= 1'b0;
                    end else begin
                        m_phase <= 1;
                    end
                end
                1: if (!hold) begin
                    if (m_cons == m_cnt) begin
                        m_phase  <= 2;
                        m_result <= m_sum;
                        m_ovfo   <= m_ovf;
                    end else begin
                        m_cons <= m_cons + 1;
                    end
                end
                default: if (result_ready) m_phase <= 0;
            endcase
        end
    end

    function automatic logic [AW-1:0] exp_addr();
        return m_base + AW'(m_cons);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_phase == 1));
        chk("result_valid", 64'(result_valid), 64'(m_phase == 2));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr()));
        if (m_phase != 1) begin
            chk("result", 64'(result), 64'(m_result));
            chk("overflow", 64'(overflow), 64'(m_ovfo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int k;
        k = 0;
        while (!result_valid && k < bound) begin
            tick();
            k++;
        end
        if (!result_valid) chk({name, "_timeout"}, 64'(result_valid), 64'd1);
    endtask

    // Directed job: hold is raised in cycles [hlo,hhi] and in cycle hx, where
    // cycle 1 is the first cycle after the start edge.
    task automatic run_job(input string name, input int mode, input logic [AW-1:0] b,
                           input logic [CW-1:0] c, input int hlo, input int hhi, input int hx,
                           input int exp_cyc, input logic [DW-1:0] exp_res, input logic exp_ovf);
        int k;
        rom_mode = mode;
        base     = b;
        count    = c;
        start    = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        while (!result_valid && k < 400) begin
            hold = ((k >= hlo) && (k <= hhi)) || (k == hx);
            tick();
            k++;
        end
        hold = 1'b0;
        chk({name, "_latency"}, 64'(k), 64'(exp_cyc));
        chk({name, "_result"}, 64'(result), 64'(exp_res));
        chk({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        chk({name, "_model_result"}, 64'(m_result), 64'(exp_res));
        chk({name, "_model_overflow"}, 64'(m_ovfo), 64'(exp_ovf));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({name, "_idle"}, 64'({busy, result_valid}), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("reset_outputs", 64'({mem_addr, busy, result_valid, overflow}), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        reset = 1'b1;
        tick();

        run_job("sum10", 1, 30'd1, 16'd10, 0, 0, 0, 12, 32'd55, 1'b0);
        run_job("count0", 1, 30'd123, 16'd0, 0, 0, 0, 1, 32'd0, 1'b0);
        chk("count0_addr", 64'(mem_addr), 64'd123);
        run_job("hold", 1, 30'd1, 16'd10, 3, 5, 14, 16, 32'd55, 1'b0);
        run_job("ovf", 2, 30'd200, 16'd2, 0, 0, 0, 4, 32'h8000_0000, 1'b1);

        // index wraps at the top of the word-address space
        rom_mode = 0;
        base  = 30'h3FFF_FFFF;
        count = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wrap_addr0", 64'(mem_addr), 64'h3FFF_FFFF);
        tick();
        chk("wrap_addr1", 64'(mem_addr), 64'h0);
        tick();
        chk("wrap_addr2", 64'(mem_addr), 64'h1);
        wait_valid("wrap", 20);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // start while busy is ignored; asynchronous reset mid-fetch
        base  = 30'd5000;
        count = 16'd20;
        start = 1'b1;
        tick();
        base = 30'd77;
        repeat (3) tick();
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_flags", 64'({busy, result_valid}), 64'd0);
        chk("async_reset_addr", 64'(mem_addr), 64'd0);
        chk("async_reset_result", 64'(result), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // consumer delays ready; result must be held
        rom_mode = 1;
        base  = 30'd1;
        count = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("delay", 20);
        for (int i = 0; i < 5; i++) begin
            chk("delay_result_held", 64'({result_valid, result}), {31'd0, 1'b1, 32'd15});
            tick();
        end
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        chk("done_start_ignored", 64'({busy, result_valid}), 64'd0);

        // randomized traffic against the model
        rom_mode = 0;
        for (int n = 0; n < 2500; n++) begin
            start        = ($urandom_range(0, 3) == 0);
            base         = AW'($urandom);
            count        = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(100, 300))
                                                       : CW'($urandom_range(0, 12));
            hold         = ($urandom_range(0, 3) == 0);
            result_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        start = 1'b0;
        hold  = 1'b0;
        result_ready = 1'b1;
        begin
            int k;
            k = 0;
            while ((busy || result_valid) && k < 400) begin
                tick();
                k++;
            end
            chk("final_idle", 64'({busy, result_valid}), 64'd0);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
